// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control FSM: states, opcodes,
// ALU/writeback selects, trap causes and the opcode class bundle.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_START  = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_ADDR   = 4'd3,
        ST_MEM    = 4'd4,
        ST_EXEC_R = 4'd5,
        ST_BRANCH = 4'd6,
        ST_WB     = 4'd7,
        ST_TRAP   = 4'd8
    } state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;
    localparam logic [1:0] WB_TGT    = 2'b11;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_IMEM    = 2'b10;
    localparam logic [1:0] CAUSE_DMEM    = 2'b11;

    typedef struct packed {
        logic load;
        logic store;
        logic branch;
        logic auipc;
        logic jal;
        logic rtype;
        logic illegal;
    } op_class_t;

    // Wait counter must hold values up to the limit; never narrower than one bit.
    function automatic int cnt_width(input int limit);
        return (limit < 2) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Control bundle between the multicycle FSM (master) and the datapath/memory side (slave).
interface mc_ctrl_if;

    logic [31:0] instr;
    logic        br_taken;
    logic        imem_ack;
    logic        dmem_ack;
    logic        imem_req;
    logic        ir_we;
    logic        pc_we;
    logic        pc_src;
    logic        tgt_we;
    logic        alu_a_sel;
    logic        alu_b_sel;
    logic [1:0]  alu_op;
    logic        aluout_we;
    logic        dmem_req;
    logic        dmem_we;
    logic        mdr_we;
    logic        reg_we;
    logic [1:0]  wb_sel;
    logic        retire;
    logic        trap;
    logic [1:0]  trap_cause;

    modport master (
        input  instr, br_taken, imem_ack, dmem_ack,
        output imem_req, ir_we, pc_we, pc_src, tgt_we, alu_a_sel, alu_b_sel, alu_op,
               aluout_we, dmem_req, dmem_we, mdr_we, reg_we, wb_sel, retire, trap, trap_cause
    );

    modport slave (
        output instr, br_taken, imem_ack, dmem_ack,
        input  imem_req, ir_we, pc_we, pc_src, tgt_we, alu_a_sel, alu_b_sel, alu_op,
               aluout_we, dmem_req, dmem_we, mdr_we, reg_we, wb_sel, retire, trap, trap_cause
    );

endinterface

// File: rtl/mc_ctrl_op_class.sv
// Combinational opcode classifier: instr[6:0] to a one-hot instruction class.
module mc_ctrl_op_class
    import mc_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output op_class_t  cls
);

    always_comb begin
        cls = '0;
        case (opcode)
            OPC_LOAD:   cls.load    = 1'b1;
            OPC_STORE:  cls.store   = 1'b1;
            OPC_BRANCH: cls.branch  = 1'b1;
            OPC_AUIPC:  cls.auipc   = 1'b1;
            OPC_JAL:    cls.jal     = 1'b1;
            OPC_RTYPE:  cls.rtype   = 1'b1;
            default:    cls.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// and halts with a sticky trap on illegal opcode or acknowledge timeout.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255
)
(
    input  logic      clk,
    input  logic      rst,
    mc_ctrl_if.master bus
);

    localparam int             CNT_W      = cnt_width(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(ACK_TIMEOUT);
    localparam bit             TIMEOUT_EN = (ACK_TIMEOUT != 0);

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             trap_q;
    logic [1:0]       cause_q;
    op_class_t        cls;
    logic             wait_expired;

    mc_ctrl_op_class u_op_class (
        .opcode (bus.instr[6:0]),
        .cls    (cls)
    );

    // The limit is reached on the cycle whose wait would bring the count to ACK_TIMEOUT.
    assign wait_expired = TIMEOUT_EN && ((wait_cnt + CNT_W'(1)) == LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_START;
            wait_cnt <= '0;
            trap_q   <= 1'b0;
            cause_q  <= CAUSE_NONE;
        end else begin
            wait_cnt <= '0;
            case (state)
                ST_START: state <= ST_FETCH;
                ST_FETCH: begin
                    if (bus.imem_ack) begin
                        state <= ST_DECODE;
                    end else if (wait_expired) begin
                        state   <= ST_TRAP;
                        trap_q  <= 1'b1;
                        cause_q <= CAUSE_IMEM;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                ST_DECODE: begin
                    if (cls.illegal) begin
                        state   <= ST_TRAP;
                        trap_q  <= 1'b1;
                        cause_q <= CAUSE_ILLEGAL;
                    end else if (cls.load || cls.store) begin
                        state <= ST_ADDR;
                    end else if (cls.rtype) begin
                        state <= ST_EXEC_R;
                    end else if (cls.branch) begin
                        state <= ST_BRANCH;
                    end else begin
                        state <= ST_WB;
                    end
                end
                ST_ADDR:   state <= ST_MEM;
                ST_MEM: begin
                    if (bus.dmem_ack) begin
                        state <= cls.store ? ST_FETCH : ST_WB;
                    end else if (wait_expired) begin
                        state   <= ST_TRAP;
                        trap_q  <= 1'b1;
                        cause_q <= CAUSE_DMEM;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                ST_EXEC_R: state <= ST_WB;
                ST_BRANCH: state <= ST_FETCH;
                ST_WB:     state <= ST_FETCH;
                ST_TRAP:   state <= ST_TRAP;
                default:   state <= ST_START;
            endcase
        end
    end

    assign bus.trap       = trap_q;
    assign bus.trap_cause = cause_q;

    // Datapath controls follow the current state, qualified by ack/br_taken where needed.
    always_comb begin
        bus.imem_req  = 1'b0;
        bus.ir_we     = 1'b0;
        bus.pc_we     = 1'b0;
        bus.pc_src    = 1'b0;
        bus.tgt_we    = 1'b0;
        bus.alu_a_sel = 1'b0;
        bus.alu_b_sel = 1'b0;
        bus.alu_op    = ALU_ADD;
        bus.aluout_we = 1'b0;
        bus.dmem_req  = 1'b0;
        bus.dmem_we   = 1'b0;
        bus.mdr_we    = 1'b0;
        bus.reg_we    = 1'b0;
        bus.wb_sel    = WB_ALUOUT;
        bus.retire    = 1'b0;
        case (state)
            ST_FETCH: begin
                bus.imem_req = 1'b1;
                bus.ir_we    = bus.imem_ack;
                bus.pc_we    = bus.imem_ack;
            end
            ST_DECODE: bus.tgt_we = 1'b1;
            ST_ADDR: begin
                bus.alu_a_sel = 1'b1;
                bus.aluout_we = 1'b1;
            end
            ST_MEM: begin
                bus.dmem_req = 1'b1;
                bus.dmem_we  = cls.store;
                bus.mdr_we   = bus.dmem_ack && !cls.store;
                bus.retire   = bus.dmem_ack && cls.store;
            end
            ST_EXEC_R: begin
                bus.alu_a_sel = 1'b1;
                bus.alu_b_sel = 1'b1;
                bus.alu_op    = ALU_FUNCT;
                bus.aluout_we = 1'b1;
            end
            ST_BRANCH: begin
                bus.pc_we  = bus.br_taken;
                bus.pc_src = 1'b1;
                bus.retire = 1'b1;
            end
            ST_WB: begin
                bus.reg_we = 1'b1;
                bus.retire = 1'b1;
                if (cls.load) begin
                    bus.wb_sel = WB_MDR;
                end else if (cls.auipc) begin
                    bus.wb_sel = WB_TGT;
                end else if (cls.jal) begin
                    // Link is captured from the old PC while PC takes the target this cycle.
                    bus.wb_sel = WB_PC;
                    bus.pc_we  = 1'b1;
                    bus.pc_src = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: walks each instruction class, timeouts, traps
// and resets, checking the full control vector every cycle.
module tb_mc_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mc_ctrl_if bus ();

    mc_ctrl #(.ACK_TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    localparam logic [19:0] IMEM_REQ  = 20'h80000;
    localparam logic [19:0] IR_WE     = 20'h40000;
    localparam logic [19:0] PC_WE     = 20'h20000;
    localparam logic [19:0] PC_SRC    = 20'h10000;
    localparam logic [19:0] TGT_WE    = 20'h08000;
    localparam logic [19:0] A_SEL     = 20'h04000;
    localparam logic [19:0] B_SEL     = 20'h02000;
    localparam logic [19:0] OP_FUNCT  = 20'h01000;
    localparam logic [19:0] ALUOUT_WE = 20'h00400;
    localparam logic [19:0] DMEM_REQ  = 20'h00200;
    localparam logic [19:0] DMEM_WE   = 20'h00100;
    localparam logic [19:0] MDR_WE    = 20'h00080;
    localparam logic [19:0] REG_WE    = 20'h00040;
    localparam logic [19:0] WB_PC     = 20'h00020;
    localparam logic [19:0] WB_MDR    = 20'h00010;
    localparam logic [19:0] WB_TGT    = 20'h00030;
    localparam logic [19:0] RETIRE    = 20'h00008;
    localparam logic [19:0] TRAP      = 20'h00004;
    localparam logic [19:0] CAUSE_ILL = 20'h00001;
    localparam logic [19:0] CAUSE_IM  = 20'h00002;
    localparam logic [19:0] CAUSE_DM  = 20'h00003;
    localparam logic [19:0] NONE      = 20'h00000;

    localparam logic [31:0] LW    = 32'h00412083;
    localparam logic [31:0] SW    = 32'h0020A223;
    localparam logic [31:0] BEQ   = 32'h00208463;
    localparam logic [31:0] ADD   = 32'h002081B3;
    localparam logic [31:0] AUIPC = 32'h00001097;
    localparam logic [31:0] JAL   = 32'h008000EF;
    localparam logic [31:0] ADDI  = 32'h00000013;

    localparam logic [19:0] FETCH_ACK = IMEM_REQ | IR_WE | PC_WE;

    function automatic logic [19:0] observed();
        return {bus.imem_req, bus.ir_we, bus.pc_we, bus.pc_src, bus.tgt_we,
                bus.alu_a_sel, bus.alu_b_sel, bus.alu_op, bus.aluout_we,
                bus.dmem_req, bus.dmem_we, bus.mdr_we, bus.reg_we, bus.wb_sel,
                bus.retire, bus.trap, bus.trap_cause};
    endfunction

    task automatic checkOutput(input string tag, input logic [19:0] expected);
        logic [19:0] obs;
        obs = observed();
        checks++;
        assert (obs === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%05h expected=%05h", tag, obs, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] ins, input logic br,
                                 input logic iack, input logic dack);
        @(posedge clk);
        #2;
        bus.instr    = ins;
        bus.br_taken = br;
        bus.imem_ack = iack;
        bus.dmem_ack = dack;
        #1;
    endtask

    task automatic step(input string tag, input logic [31:0] ins, input logic br,
                        input logic iack, input logic dack, input logic [19:0] expected);
        applyStimulus(ins, br, iack, dack);
        checkOutput(tag, expected);
    endtask

    task automatic doReset();
        rst          = 1'b1;
        bus.br_taken = 1'b0;
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        #1;
        checkOutput("reset_asserted", NONE);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checkOutput("start_state", NONE);
    endtask

    initial begin
        rst          = 1'b1;
        bus.instr    = 32'h0;
        bus.br_taken = 1'b0;
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        @(posedge clk);
        #3;
        doReset();

        // LOAD, immediate fetch ack, three data wait cycles: 8 cycles to retire
        step("ld_fetch",  LW, 0, 1, 0, FETCH_ACK);
        step("ld_decode", LW, 0, 0, 0, TGT_WE);
        step("ld_addr",   LW, 0, 0, 0, A_SEL | ALUOUT_WE);
        for (int i = 0; i < 3; i++) step("ld_mem_wait", LW, 0, 0, 0, DMEM_REQ);
        step("ld_mem_ack", LW, 0, 0, 1, DMEM_REQ | MDR_WE);
        step("ld_wb",      LW, 0, 0, 0, REG_WE | WB_MDR | RETIRE);

        // STORE, fetch ack on the 4th cycle (limit cycle) still wins
        for (int i = 0; i < 3; i++) step("sw_fetch_wait", LW, 0, 0, 0, IMEM_REQ);
        step("sw_fetch_ack_at_limit", SW, 0, 1, 0, FETCH_ACK);
        step("sw_decode",  SW, 0, 0, 0, TGT_WE);
        step("sw_addr",    SW, 0, 0, 0, A_SEL | ALUOUT_WE);
        step("sw_mem_ack", SW, 0, 0, 1, DMEM_REQ | DMEM_WE | RETIRE);

        // BEQ taken then not taken
        step("beq1_fetch",  BEQ, 0, 1, 0, FETCH_ACK);
        step("beq1_decode", BEQ, 0, 0, 0, TGT_WE);
        step("beq_taken",   BEQ, 1, 0, 0, PC_WE | PC_SRC | RETIRE);
        step("beq2_fetch",  BEQ, 0, 1, 0, FETCH_ACK);
        step("beq2_decode", BEQ, 0, 0, 0, TGT_WE);
        step("beq_not_taken", BEQ, 0, 0, 0, PC_SRC | RETIRE);

        // R-type
        step("add_fetch",  ADD, 0, 1, 0, FETCH_ACK);
        step("add_decode", ADD, 0, 0, 0, TGT_WE);
        step("add_exec",   ADD, 0, 0, 0, A_SEL | B_SEL | OP_FUNCT | ALUOUT_WE);
        step("add_wb",     ADD, 0, 0, 0, REG_WE | RETIRE);

        // AUIPC, with stray acks during DECODE that must be ignored
        step("auipc_fetch",  AUIPC, 0, 1, 0, FETCH_ACK);
        step("auipc_decode_stray_acks", AUIPC, 0, 1, 1, TGT_WE);
        step("auipc_wb",     AUIPC, 0, 0, 0, REG_WE | WB_TGT | RETIRE);

        // JAL writes link and redirects PC in the same cycle
        step("jal_fetch",  JAL, 0, 1, 0, FETCH_ACK);
        step("jal_decode", JAL, 0, 0, 0, TGT_WE);
        step("jal_wb",     JAL, 0, 0, 0, REG_WE | WB_PC | PC_WE | PC_SRC | RETIRE);

        // Reset while waiting in MEM aborts immediately
        step("rm_fetch",  LW, 0, 1, 0, FETCH_ACK);
        step("rm_decode", LW, 0, 0, 0, TGT_WE);
        step("rm_addr",   LW, 0, 0, 0, A_SEL | ALUOUT_WE);
        step("rm_mem",    LW, 0, 0, 0, DMEM_REQ);
        doReset();
        step("post_reset_fetch", LW, 0, 0, 0, IMEM_REQ);

        // STORE with no data ack: trap after four wait cycles
        step("dto_fetch",  SW, 0, 1, 0, FETCH_ACK);
        step("dto_decode", SW, 0, 0, 0, TGT_WE);
        step("dto_addr",   SW, 0, 0, 0, A_SEL | ALUOUT_WE);
        for (int i = 0; i < 4; i++) step("dto_mem_wait", SW, 0, 0, 0, DMEM_REQ | DMEM_WE);
        step("dmem_timeout",      SW, 0, 0, 0, TRAP | CAUSE_DM);
        step("trap_acks_ignored", SW, 1, 1, 1, TRAP | CAUSE_DM);

        // No instruction ack: trap after four wait cycles
        doReset();
        for (int i = 0; i < 4; i++) step("ito_fetch_wait", LW, 0, 0, 0, IMEM_REQ);
        step("imem_timeout", LW, 0, 0, 0, TRAP | CAUSE_IM);

        // Illegal opcode
        doReset();
        step("ill_fetch",  ADDI, 0, 1, 0, FETCH_ACK);
        step("ill_decode", ADDI, 0, 0, 0, TGT_WE);
        step("ill_trap",   ADDI, 0, 0, 0, TRAP | CAUSE_ILL);
        step("ill_trap_sticky", ADDI, 0, 1, 0, TRAP | CAUSE_ILL);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
